// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the fully-associative cache tag controller:
//   - geometry localparams (address width, way index width, line offset width)
//   - tag-width helper function and derived TAG_WID / NUM_WAYS
//   - controller state enum (IDLE, LOOKUP, REFILL, RESP)
//   - response struct (hit flag + way index)
// -----------------------------------------------------------------------------
package cache_pkg;

   localparam int unsigned WORD_WID   = 64;
   localparam int unsigned IDX_WID    = 3;
   localparam int unsigned OFFSET_WID = 6;
   localparam int unsigned NUM_WAYS   = 1 << IDX_WID;

   // Tag bits are whatever is left of the address above the line offset.
   function automatic int unsigned tag_width(input int unsigned word_w,
                                             input int unsigned off_w);
      return word_w - off_w;
   endfunction

   localparam int unsigned TAG_WID = tag_width(WORD_WID, OFFSET_WID);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_REFILL = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   typedef struct packed {
      logic               hit;
      logic [IDX_WID-1:0] way;
   } resp_t;

endpackage

// File: rtl/cache_tag_match.sv
// -----------------------------------------------------------------------------
// cache_tag_match
// Combinational tag match logic for the fully-associative tag store.
// Ports:
//   tags_i       - tag of every way
//   valid_i      - valid bit of every way
//   tag_i        - tag being looked up
//   hit_o        - some valid way holds tag_i
//   hit_idx_o    - index of the matching way (lowest index if several match)
//   any_inval_o  - at least one way is invalid
//   inval_idx_o  - lowest-numbered invalid way (0 when none)
// -----------------------------------------------------------------------------
module cache_tag_match
   import cache_pkg::*;
(
   input  logic [NUM_WAYS-1:0][TAG_WID-1:0] tags_i,
   input  logic [NUM_WAYS-1:0]              valid_i,
   input  logic [TAG_WID-1:0]               tag_i,
   output logic                             hit_o,
   output logic [IDX_WID-1:0]               hit_idx_o,
   output logic                             any_inval_o,
   output logic [IDX_WID-1:0]               inval_idx_o
);

   logic [NUM_WAYS-1:0] match_s;

   // Valid-qualified per-way tag comparators.
   always_comb begin
      match_s = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         match_s[w] = valid_i[w] && (tags_i[w] == tag_i);
      end
   end

   // One-hot to index; scanning downwards lets the lowest match win.
   always_comb begin
      hit_idx_o = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (match_s[w]) begin
            hit_idx_o = IDX_WID'(w);
         end else begin
            hit_idx_o = hit_idx_o;
         end
      end
   end

   assign hit_o = |match_s;

   // Lowest invalid way finder, same downward scan.
   always_comb begin
      inval_idx_o = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_i[w]) begin
            inval_idx_o = IDX_WID'(w);
         end else begin
            inval_idx_o = inval_idx_o;
         end
      end
   end

   assign any_inval_o = ~&valid_i;

endmodule

// File: rtl/cache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// cache_tag_ctrl
// Fully-associative tag store and miss-handling controller. Accepts lookup and
// invalidate requests, compares against every way, drives the external LRU
// tracker, and sequences line refills over a req/ack handshake.
// Ports:
//   clk_i, rst_i            - clock, asynchronous active-high reset
//   req_valid_i/ready_o     - request handshake (ready only in IDLE)
//   req_inval_i, req_addr_i - request kind and address
//   resp_valid_o/hit_o/way_o- single-cycle response
//   refill_req_o/addr_o     - level refill request, line-aligned address
//   refill_ack_i            - refill complete (only honoured in REFILL)
//   lru_en_o/hit_o/valid_o/idx_o  - LRU update strobe
//   lru_inval_o/inval_idx_o - LRU invalidate strobe
//   lru_victim_i            - LRU victim way, sampled in the ack cycle
//   hit_cnt_o, miss_cnt_o   - statistics counters
// Configuration macro: CACHE_STATS_EN builds the saturating hit/miss counters;
// without it both counter outputs are tied to zero.
// LRU and response strobes are registered, so they all appear together in the
// single RESP cycle that follows LOOKUP or the refill ack.
// -----------------------------------------------------------------------------
module cache_tag_ctrl
   import cache_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_inval_i,
   input  logic [WORD_WID-1:0] req_addr_i,
   output logic                resp_valid_o,
   output logic                resp_hit_o,
   output logic [IDX_WID-1:0]  resp_way_o,
   output logic                refill_req_o,
   output logic [WORD_WID-1:0] refill_addr_o,
   input  logic                refill_ack_i,
   output logic                lru_en_o,
   output logic                lru_hit_o,
   output logic                lru_valid_o,
   output logic [IDX_WID-1:0]  lru_idx_o,
   output logic                lru_inval_o,
   output logic [IDX_WID-1:0]  lru_inval_idx_o,
   input  logic [IDX_WID-1:0]  lru_victim_i,
   output logic [31:0]         hit_cnt_o,
   output logic [31:0]         miss_cnt_o
);

   state_e                           state_q;
   logic [NUM_WAYS-1:0]              valid_q;
   logic [NUM_WAYS-1:0][TAG_WID-1:0] tags_q;
   logic [TAG_WID-1:0]               addr_tag_q;
   logic                             inval_q;
   logic                             refill_req_q;
   logic [WORD_WID-1:0]              refill_addr_q;
   logic                             resp_valid_q;
   resp_t                            resp_q;
   logic                             lru_en_q;
   logic                             lru_hit_q;
   logic                             lru_valid_q;
   logic [IDX_WID-1:0]               lru_idx_q;
   logic                             lru_inval_q;
   logic [IDX_WID-1:0]               lru_inval_idx_q;

   logic                             hit_s;
   logic [IDX_WID-1:0]               hit_idx_s;
   logic                             any_inval_s;
   logic [IDX_WID-1:0]               inval_idx_s;
   logic [IDX_WID-1:0]               fill_way_d;

   // The line offset never takes part in tag compare.
   logic                             unused_offset_s;
   assign unused_offset_s = ^req_addr_i[OFFSET_WID-1:0];

   cache_tag_match u_match (
      .tags_i      (tags_q),
      .valid_i     (valid_q),
      .tag_i       (addr_tag_q),
      .hit_o       (hit_s),
      .hit_idx_o   (hit_idx_s),
      .any_inval_o (any_inval_s),
      .inval_idx_o (inval_idx_s)
   );

   // Fill into an empty way first; only evict the LRU victim when full.
   always_comb begin
      if (any_inval_s) begin
         fill_way_d = inval_idx_s;
      end else begin
         fill_way_d = lru_victim_i;
      end
   end

   // Controller FSM with its registered outputs and the valid bits.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         valid_q         <= '0;
         addr_tag_q      <= '0;
         inval_q         <= 1'b0;
         refill_req_q    <= 1'b0;
         refill_addr_q   <= '0;
         resp_valid_q    <= 1'b0;
         resp_q          <= '0;
         lru_en_q        <= 1'b0;
         lru_hit_q       <= 1'b0;
         lru_valid_q     <= 1'b0;
         lru_idx_q       <= '0;
         lru_inval_q     <= 1'b0;
         lru_inval_idx_q <= '0;
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         resp_valid_q    <= 1'b0;
         lru_en_q        <= 1'b0;
         lru_hit_q       <= 1'b0;
         lru_valid_q     <= 1'b0;
         lru_idx_q       <= '0;
         lru_inval_q     <= 1'b0;
         lru_inval_idx_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  addr_tag_q <= req_addr_i[WORD_WID-1:OFFSET_WID];
                  inval_q    <= req_inval_i;
                  state_q    <= ST_LOOKUP;
               end else begin
                  state_q    <= ST_IDLE;
               end
            end
            ST_LOOKUP: begin
               if (inval_q) begin
                  if (hit_s) begin
                     valid_q[hit_idx_s] <= 1'b0;
                     lru_inval_q        <= 1'b1;
                     lru_inval_idx_q    <= hit_idx_s;
                     resp_q             <= '{hit: 1'b1, way: hit_idx_s};
                  end else begin
                     resp_q             <= '{hit: 1'b0, way: '0};
                  end
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_RESP;
               end else if (hit_s) begin
                  lru_en_q     <= 1'b1;
                  lru_hit_q    <= 1'b1;
                  lru_valid_q  <= 1'b1;
                  lru_idx_q    <= hit_idx_s;
                  resp_q       <= '{hit: 1'b1, way: hit_idx_s};
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  refill_req_q  <= 1'b1;
                  refill_addr_q <= {addr_tag_q, {OFFSET_WID{1'b0}}};
                  state_q       <= ST_REFILL;
               end
            end
            ST_REFILL: begin
               if (refill_ack_i) begin
                  refill_req_q        <= 1'b0;
                  valid_q[fill_way_d] <= 1'b1;
                  lru_en_q            <= 1'b1;
                  lru_valid_q         <= 1'b1;
                  lru_idx_q           <= fill_way_d;
                  resp_q              <= '{hit: 1'b0, way: fill_way_d};
                  resp_valid_q        <= 1'b1;
                  state_q             <= ST_RESP;
               end else begin
                  state_q             <= ST_REFILL;
               end
            end
            ST_RESP: begin
               resp_q  <= '0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Tag array: contents survive reset, only the valid bits are cleared.
   always_ff @(posedge clk_i) begin
      if ((state_q == ST_REFILL) && refill_ack_i) begin
         tags_q[fill_way_d] <= addr_tag_q;
      end else begin
         tags_q <= tags_q;
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Saturating counters of lookup hits and misses; invalidates are skipped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
      end else if ((state_q == ST_LOOKUP) && !inval_q) begin
         if (hit_s) begin
            if (hit_cnt_q != 32'hFFFF_FFFF) begin
               hit_cnt_q <= hit_cnt_q + 32'd1;
            end
         end else begin
            if (miss_cnt_q != 32'hFFFF_FFFF) begin
               miss_cnt_q <= miss_cnt_q + 32'd1;
            end
         end
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`else
   assign hit_cnt_o  = 32'd0;
   assign miss_cnt_o = 32'd0;
`endif

   assign req_ready_o     = (state_q == ST_IDLE);
   assign resp_valid_o    = resp_valid_q;
   assign resp_hit_o      = resp_q.hit;
   assign resp_way_o      = resp_q.way;
   assign refill_req_o    = refill_req_q;
   assign refill_addr_o   = refill_addr_q;
   assign lru_en_o        = lru_en_q;
   assign lru_hit_o       = lru_hit_q;
   assign lru_valid_o     = lru_valid_q;
   assign lru_idx_o       = lru_idx_q;
   assign lru_inval_o     = lru_inval_q;
   assign lru_inval_idx_o = lru_inval_idx_q;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_tag_ctrl
// Directed self-checking bench for cache_tag_ctrl. Inputs are driven 1 ns
// after the rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_cache_tag_ctrl;

   logic        clk_i;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_inval_i;
   logic [63:0] req_addr_i;
   logic        resp_valid_o;
   logic        resp_hit_o;
   logic [2:0]  resp_way_o;
   logic        refill_req_o;
   logic [63:0] refill_addr_o;
   logic        refill_ack_i;
   logic        lru_en_o;
   logic        lru_hit_o;
   logic        lru_valid_o;
   logic [2:0]  lru_idx_o;
   logic        lru_inval_o;
   logic [2:0]  lru_inval_idx_o;
   logic [2:0]  lru_victim_i;
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;

   int checks;
   int errors;

   typedef struct {
      logic        refill;
      logic [63:0] raddr;
      logic        rvalid;
      logic        rhit;
      logic [2:0]  rway;
      logic        len;
      logic        lhit;
      logic        lval;
      logic [2:0]  lidx;
      logic        linv;
      logic [2:0]  linv_idx;
   } obs_t;

   cache_tag_ctrl dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_inval_i     (req_inval_i),
      .req_addr_i      (req_addr_i),
      .resp_valid_o    (resp_valid_o),
      .resp_hit_o      (resp_hit_o),
      .resp_way_o      (resp_way_o),
      .refill_req_o    (refill_req_o),
      .refill_addr_o   (refill_addr_o),
      .refill_ack_i    (refill_ack_i),
      .lru_en_o        (lru_en_o),
      .lru_hit_o       (lru_hit_o),
      .lru_valid_o     (lru_valid_o),
      .lru_idx_o       (lru_idx_o),
      .lru_inval_o     (lru_inval_o),
      .lru_inval_idx_o (lru_inval_idx_o),
      .lru_victim_i    (lru_victim_i),
      .hit_cnt_o       (hit_cnt_o),
      .miss_cnt_o      (miss_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      #2;
      rst_i = 1'b0;
      step();
   endtask

   // One request end-to-end. A miss is acked three cycles after refill_req_o
   // first shows up. Response/strobes are captured in the RESP cycle.
   task automatic access(input logic [63:0] addr, input logic inval,
                         input logic [2:0] victim, output obs_t o);
      req_valid_i  = 1'b1;
      req_addr_i   = addr;
      req_inval_i  = inval;
      lru_victim_i = victim;
      step();                 // cycle 1: LOOKUP
      req_valid_i  = 1'b0;
      step();                 // cycle 2: RESP or REFILL
      o.refill = refill_req_o;
      o.raddr  = refill_addr_o;
      if (refill_req_o) begin
         step();
         step();
         refill_ack_i = 1'b1;
         step();
         refill_ack_i = 1'b0;
      end
      o.rvalid   = resp_valid_o;
      o.rhit     = resp_hit_o;
      o.rway     = resp_way_o;
      o.len      = lru_en_o;
      o.lhit     = lru_hit_o;
      o.lval     = lru_valid_o;
      o.lidx     = lru_idx_o;
      o.linv     = lru_inval_o;
      o.linv_idx = lru_inval_idx_o;
      step();                 // back to IDLE
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({req_ready_o, resp_valid_o, refill_req_o, lru_en_o, lru_inval_o} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 10000",
                  {req_ready_o, resp_valid_o, refill_req_o, lru_en_o, lru_inval_o});
      end
      checks++;
      if ({hit_cnt_o, miss_cnt_o, refill_addr_o} !== 128'd0) begin
         errors++;
         $display("FAIL reset_data got hit=%0d miss=%0d raddr=%h want zeros",
                  hit_cnt_o, miss_cnt_o, refill_addr_o);
      end
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_miss_refill();
      obs_t o;
      access(64'h1000, 1'b0, 3'd3, o);
      checks++;
      if ({o.refill, o.raddr} !== {1'b1, 64'h1000}) begin
         errors++;
         $display("FAIL miss_refill_req got req=%b addr=%h want 1 0x1000", o.refill, o.raddr);
      end
      checks++;
      if ({o.rvalid, o.rhit, o.rway} !== {1'b1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL miss_resp got v=%b h=%b w=%0d want 1 0 0", o.rvalid, o.rhit, o.rway);
      end
      checks++;
      if ({o.len, o.lhit, o.lval, o.lidx} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL miss_lru got en=%b hit=%b val=%b idx=%0d want 1 0 1 0",
                  o.len, o.lhit, o.lval, o.lidx);
      end
   endtask

   task automatic test_hit();
      // Manual stepping to check ready drops during LOOKUP and response timing.
      req_valid_i = 1'b1;
      req_addr_i  = 64'h1008;
      req_inval_i = 1'b0;
      step();
      req_valid_i = 1'b0;
      checks++;
      if ({req_ready_o, resp_valid_o} !== 2'b00) begin
         errors++;
         $display("FAIL hit_lookup_cycle got ready=%b valid=%b want 0 0", req_ready_o, resp_valid_o);
      end
      step();
      checks++;
      if ({resp_valid_o, resp_hit_o, resp_way_o, refill_req_o} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL hit_resp got v=%b h=%b w=%0d refill=%b want 1 1 0 0",
                  resp_valid_o, resp_hit_o, resp_way_o, refill_req_o);
      end
      checks++;
      if ({lru_en_o, lru_hit_o, lru_valid_o, lru_idx_o} !== {1'b1, 1'b1, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL hit_lru got en=%b hit=%b val=%b idx=%0d want 1 1 1 0",
                  lru_en_o, lru_hit_o, lru_valid_o, lru_idx_o);
      end
      step();
      checks++;
      if ({req_ready_o, resp_valid_o, lru_en_o} !== 3'b100) begin
         errors++;
         $display("FAIL hit_pulse_end got ready=%b valid=%b lru=%b want 1 0 0",
                  req_ready_o, resp_valid_o, lru_en_o);
      end
   endtask

   task automatic test_fill();
      obs_t o;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         access(64'(i) * 64'h40, 1'b0, 3'(7 - i), o);
         checks++;
         if ({o.refill, o.rvalid, o.rhit, o.rway} !== {1'b1, 1'b1, 1'b0, 3'(i)}) begin
            errors++;
            $display("FAIL fill_way%0d got refill=%b v=%b h=%b w=%0d want 1 1 0 %0d",
                     i, o.refill, o.rvalid, o.rhit, o.rway, i);
         end
      end
      access(64'h200, 1'b0, 3'd5, o);
      checks++;
      if ({o.refill, o.rway, o.lidx} !== {1'b1, 3'd5, 3'd5}) begin
         errors++;
         $display("FAIL fill_victim got refill=%b w=%0d lidx=%0d want 1 5 5", o.refill, o.rway, o.lidx);
      end
      // 0x140 lived in way 5 and was evicted; it refills into victim way 2.
      access(64'h140, 1'b0, 3'd2, o);
      checks++;
      if ({o.refill, o.raddr, o.rhit, o.rway} !== {1'b1, 64'h140, 1'b0, 3'd2}) begin
         errors++;
         $display("FAIL evicted_miss got refill=%b addr=%h h=%b w=%0d want 1 0x140 0 2",
                  o.refill, o.raddr, o.rhit, o.rway);
      end
      access(64'h1C4, 1'b0, 3'd0, o);
      checks++;
      if ({o.refill, o.rhit, o.rway} !== {1'b0, 1'b1, 3'd7}) begin
         errors++;
         $display("FAIL hit_way7 got refill=%b h=%b w=%0d want 0 1 7", o.refill, o.rhit, o.rway);
      end
   endtask

   task automatic test_invalidate();
      obs_t o;
      access(64'h040, 1'b1, 3'd4, o);
      checks++;
      if ({o.rvalid, o.rhit, o.rway, o.linv, o.linv_idx, o.len} !==
          {1'b1, 1'b1, 3'd1, 1'b1, 3'd1, 1'b0}) begin
         errors++;
         $display("FAIL inval_hit got v=%b h=%b w=%0d inv=%b idx=%0d en=%b want 1 1 1 1 1 0",
                  o.rvalid, o.rhit, o.rway, o.linv, o.linv_idx, o.len);
      end
      access(64'h240, 1'b0, 3'd4, o);
      checks++;
      if ({o.refill, o.rway} !== {1'b1, 3'd1}) begin
         errors++;
         $display("FAIL fill_after_inval got refill=%b w=%0d want 1 1", o.refill, o.rway);
      end
      access(64'h800, 1'b1, 3'd4, o);
      checks++;
      if ({o.refill, o.rvalid, o.rhit, o.rway, o.linv} !== {1'b0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL inval_miss got refill=%b v=%b h=%b w=%0d inv=%b want 0 1 0 0 0",
                  o.refill, o.rvalid, o.rhit, o.rway, o.linv);
      end
   endtask

   task automatic test_reset_refill();
      obs_t o;
      do_reset();
      access(64'h1000, 1'b0, 3'd0, o);
      access(64'h1000, 1'b0, 3'd0, o);
      checks++;
      if ({o.refill, o.rhit} !== 2'b01) begin
         errors++;
         $display("FAIL rr_prefill_hit got refill=%b h=%b want 0 1", o.refill, o.rhit);
      end
      req_valid_i = 1'b1;
      req_addr_i  = 64'h3000;
      req_inval_i = 1'b0;
      step();
      req_valid_i = 1'b0;
      step();
      checks++;
      if (refill_req_o !== 1'b1) begin
         errors++;
         $display("FAIL rr_refill_up got %b want 1", refill_req_o);
      end
      #2;
      rst_i = 1'b1;
      #1;
      checks++;
      if ({refill_req_o, req_ready_o} !== 2'b01) begin
         errors++;
         $display("FAIL rr_async_drop got req=%b ready=%b want 0 1", refill_req_o, req_ready_o);
      end
      rst_i = 1'b0;
      step();
      access(64'h1000, 1'b0, 3'd0, o);
      checks++;
      if ({o.refill, o.rhit, o.rway} !== {1'b1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL rr_lost_line got refill=%b h=%b w=%0d want 1 0 0", o.refill, o.rhit, o.rway);
      end
   endtask

   task automatic test_stats();
      obs_t o;
      logic [31:0] exp_hit;
      logic [31:0] exp_miss;
      do_reset();
      // A stray ack in IDLE must not produce a response.
      refill_ack_i = 1'b1;
      step();
      refill_ack_i = 1'b0;
      step();
      checks++;
      if ({req_ready_o, resp_valid_o, refill_req_o} !== 3'b100) begin
         errors++;
         $display("FAIL stray_ack got ready=%b valid=%b req=%b want 1 0 0",
                  req_ready_o, resp_valid_o, refill_req_o);
      end
      access(64'h000, 1'b0, 3'd0, o);
      access(64'h040, 1'b0, 3'd0, o);
      access(64'h000, 1'b0, 3'd0, o);
      access(64'h040, 1'b0, 3'd0, o);
      access(64'h010, 1'b0, 3'd0, o);
      access(64'h040, 1'b1, 3'd0, o);
`ifdef CACHE_STATS_EN
      exp_hit  = 32'd3;
      exp_miss = 32'd2;
`else
      exp_hit  = 32'd0;
      exp_miss = 32'd0;
`endif
      checks++;
      if ({hit_cnt_o, miss_cnt_o} !== {exp_hit, exp_miss}) begin
         errors++;
         $display("FAIL stats got hit=%0d miss=%0d want %0d %0d",
                  hit_cnt_o, miss_cnt_o, exp_hit, exp_miss);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst_i        = 1'b1;
      req_valid_i  = 1'b0;
      req_inval_i  = 1'b0;
      req_addr_i   = 64'd0;
      refill_ack_i = 1'b0;
      lru_victim_i = 3'd0;
      test_reset();
      test_miss_refill();
      test_hit();
      test_fill();
      test_invalidate();
      test_reset_refill();
      test_stats();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
